// File: rtl/heater_pkg.sv
// Shared types and default sizing for the heater channel sequencer.
package heater_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int DEF_N           = 12;
    localparam int DEF_MAX_ON      = 8;
    localparam int DEF_STEP_CYCLES = 4096;
    localparam int DEF_CLR_CYCLES  = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/heater_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next fault to clear
// and the next pending channel to ramp.
module heater_prio_enc #(
    parameter int N  = 12,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/heater_sequencer.sv
// Staggered heater enable with a concurrency cap, plus automatic shed,
// error-clear and re-ramp of faulted channels.
module heater_sequencer
    import heater_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int MAX_ON      = DEF_MAX_ON,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int CLR_CYCLES  = DEF_CLR_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req_enable,
    input  logic [N-1:0]           heater_error,
    input  logic [N-1:0]           sticky_clear,
    output logic [N-1:0]           heater_enable,
    output logic [N-1:0]           heater_err_clear,
    output logic [N-1:0]           err_sticky,
    output logic [$clog2(N+1)-1:0] active_count,
    output logic [15:0]            err_count,
    output logic                   busy
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(max_int(STEP_CYCLES, CLR_CYCLES) + 1);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [IW-1:0] clr_idx;
    logic [N-1:0]  fault;

    logic [N-1:0]  shed;
    logic [N-1:0]  pending;
    logic [N-1:0]  add_mask;
    logic [N-1:0]  done_mask;
    logic [N-1:0]  enable_next;
    logic [N-1:0]  fault_next;
    logic [CW-1:0] shed_cnt;
    logic [CW-1:0] enable_cnt;
    logic [16:0]   err_sum;
    logic          start_ramp;

    logic [IW-1:0] fault_idx;
    logic          fault_vld;
    logic [IW-1:0] pend_idx;
    logic          pend_vld;

    heater_prio_enc #(.N(N), .IW(IW)) u_fault_enc (
        .vec   (fault),
        .idx   (fault_idx),
        .valid (fault_vld)
    );

    heater_prio_enc #(.N(N), .IW(IW)) u_pend_enc (
        .vec   (pending),
        .idx   (pend_idx),
        .valid (pend_vld)
    );

    // An error on an enabled channel counts as a fault even if its request
    // drops in the same cycle; errors on disabled channels are ignored.
    always_comb begin
        shed       = heater_enable & heater_error;
        pending    = req_enable & ~heater_enable & ~fault;
        start_ramp = (state == IDLE) && !fault_vld && pend_vld &&
                     (active_count < CW'(MAX_ON));
        add_mask   = start_ramp ? (ONE_HOT0 << pend_idx) : '0;
        done_mask  = ((state == CLEAR) && (timer == '0)) ? (ONE_HOT0 << clr_idx) : '0;

        enable_next = (heater_enable & req_enable & ~heater_error) | add_mask;
        fault_next  = (fault | shed) & ~done_mask;

        shed_cnt   = '0;
        enable_cnt = '0;
        for (int i = 0; i < N; i++) begin
            shed_cnt   = shed_cnt + CW'(shed[i]);
            enable_cnt = enable_cnt + CW'(enable_next[i]);
        end
        err_sum = {1'b0, err_count} + 17'(shed_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            timer            <= '0;
            clr_idx          <= '0;
            fault            <= '0;
            heater_enable    <= '0;
            heater_err_clear <= '0;
            err_sticky       <= '0;
            active_count     <= '0;
            err_count        <= '0;
            busy             <= 1'b0;
        end else begin
            heater_enable <= enable_next;
            active_count  <= enable_cnt;
            fault         <= fault_next;
            err_sticky    <= (err_sticky & ~sticky_clear) | shed;
            err_count     <= err_sum[16] ? 16'hFFFF : err_sum[15:0];

            case (state)
                IDLE: begin
                    if (fault_vld) begin
                        state            <= CLEAR;
                        busy             <= 1'b1;
                        clr_idx          <= fault_idx;
                        timer            <= TW'(CLR_CYCLES - 1);
                        heater_err_clear <= ONE_HOT0 << fault_idx;
                    end else if (start_ramp) begin
                        state <= HOLD;
                        busy  <= 1'b1;
                        timer <= TW'(STEP_CYCLES - 1);
                    end
                end

                HOLD: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                CLEAR: begin
                    if (timer == '0) begin
                        state            <= IDLE;
                        busy             <= 1'b0;
                        heater_err_clear <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                default: begin
                    state            <= IDLE;
                    busy             <= 1'b0;
                    heater_err_clear <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heater_sequencer.sv
// Directed bench for heater_sequencer with a short settling step so ramps,
// fault clears and the concurrency cap are visible within a few hundred cycles.
module tb_heater_sequencer;

    localparam int N           = 12;
    localparam int MAX_ON      = 8;
    localparam int STEP_CYCLES = 8;
    localparam int CLR_CYCLES  = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_enable;
    logic [N-1:0]  heater_error;
    logic [N-1:0]  sticky_clear;
    logic [N-1:0]  heater_enable;
    logic [N-1:0]  heater_err_clear;
    logic [N-1:0]  err_sticky;
    logic [3:0]    active_count;
    logic [15:0]   err_count;
    logic          busy;

    int checks;
    int errors;

    heater_sequencer #(
        .N           (N),
        .MAX_ON      (MAX_ON),
        .STEP_CYCLES (STEP_CYCLES),
        .CLR_CYCLES  (CLR_CYCLES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_enable       (req_enable),
        .heater_error     (heater_error),
        .sticky_clear     (sticky_clear),
        .heater_enable    (heater_enable),
        .heater_err_clear (heater_err_clear),
        .err_sticky       (err_sticky),
        .active_count     (active_count),
        .err_count        (err_count),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] err,
                                 input logic [N-1:0] sclr);
        req_enable   = req;
        heater_error = err;
        sticky_clear = sclr;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Clear pulses for the two simultaneous faults: channel 1, one idle gap, channel 5.
    logic [N-1:0] dual_clear_seq [10] = '{12'h002, 12'h002, 12'h002, 12'h002, 12'h000,
                                          12'h020, 12'h020, 12'h020, 12'h020, 12'h000};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus('0, '0, '0);
        waitCycles(2);

        checkOutput("reset_enable", 32'(heater_enable), 32'h0);
        checkOutput("reset_clear", 32'(heater_err_clear), 32'h0);
        checkOutput("reset_sticky", 32'(err_sticky), 32'h0);
        checkOutput("reset_active", 32'(active_count), 32'h0);
        checkOutput("reset_errcnt", 32'(err_count), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);

        rst_n = 1'b1;
        waitCycles(1);

        // Ramp channels 0..3, 9 cycles apart
        applyStimulus(12'h00F, '0, '0);
        waitCycles(1);
        checkOutput("ramp_en0", 32'(heater_enable), 32'h001);
        checkOutput("ramp_busy0", 32'(busy), 32'h1);
        checkOutput("ramp_active0", 32'(active_count), 32'h1);
        for (int k = 1; k < 4; k++) begin
            waitCycles(8);
            checkOutput("ramp_gap", 32'(heater_enable), 32'((1 << k) - 1));
            waitCycles(1);
            checkOutput("ramp_step", 32'(heater_enable), 32'((1 << (k + 1)) - 1));
        end
        checkOutput("ramp_active4", 32'(active_count), 32'h4);
        waitCycles(7);
        checkOutput("ramp_busy_hold", 32'(busy), 32'h1);
        waitCycles(2);
        checkOutput("ramp_busy_idle", 32'(busy), 32'h0);
        checkOutput("ramp_en_final", 32'(heater_enable), 32'h00F);

        // Single-cycle fault on channel 2
        applyStimulus(12'h00F, 12'h004, '0);
        waitCycles(1);
        applyStimulus(12'h00F, '0, '0);
        checkOutput("fault_shed", 32'(heater_enable), 32'h00B);
        checkOutput("fault_sticky", 32'(err_sticky), 32'h004);
        checkOutput("fault_errcnt", 32'(err_count), 32'h1);
        checkOutput("fault_active", 32'(active_count), 32'h3);
        checkOutput("fault_noclr_yet", 32'(heater_err_clear), 32'h0);
        waitCycles(1);
        for (int i = 0; i < CLR_CYCLES; i++) begin
            checkOutput("fault_clear_pulse", 32'(heater_err_clear), 32'h004);
            waitCycles(1);
        end
        checkOutput("fault_clear_end", 32'(heater_err_clear), 32'h0);
        checkOutput("fault_still_off", 32'(heater_enable), 32'h00B);
        waitCycles(1);
        checkOutput("fault_reenable", 32'(heater_enable), 32'h00F);
        waitCycles(9);
        checkOutput("fault_idle", 32'(busy), 32'h0);

        // Bring up channels 4 and 5, then fault 1 and 5 together
        applyStimulus(12'h03F, '0, '0);
        waitCycles(1);
        checkOutput("dual_ramp4", 32'(heater_enable), 32'h01F);
        waitCycles(9);
        checkOutput("dual_ramp5", 32'(heater_enable), 32'h03F);
        waitCycles(9);
        applyStimulus(12'h03F, 12'h022, '0);
        waitCycles(1);
        applyStimulus(12'h03F, '0, '0);
        checkOutput("dual_shed", 32'(heater_enable), 32'h01D);
        checkOutput("dual_errcnt", 32'(err_count), 32'h3);
        checkOutput("dual_sticky", 32'(err_sticky), 32'h026);
        waitCycles(1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("dual_clear_seq", 32'(heater_err_clear), 32'(dual_clear_seq[i]));
            waitCycles(1);
        end
        checkOutput("dual_reenable1", 32'(heater_enable), 32'h01F);
        waitCycles(9);
        checkOutput("dual_reenable5", 32'(heater_enable), 32'h03F);
        waitCycles(9);

        // Request drop and error on channel 3 in the same cycle
        applyStimulus(12'h037, 12'h008, '0);
        waitCycles(1);
        applyStimulus(12'h037, '0, '0);
        checkOutput("drop_err_en", 32'(heater_enable), 32'h037);
        checkOutput("drop_err_cnt", 32'(err_count), 32'h4);
        checkOutput("drop_err_sticky", 32'(err_sticky), 32'h02E);
        checkOutput("drop_err_active", 32'(active_count), 32'h5);
        waitCycles(1);
        checkOutput("drop_err_clear", 32'(heater_err_clear), 32'h008);
        waitCycles(4);
        checkOutput("drop_err_clear_end", 32'(heater_err_clear), 32'h0);
        waitCycles(2);
        checkOutput("drop_err_no_reen", 32'(heater_enable), 32'h037);
        checkOutput("drop_err_busy", 32'(busy), 32'h0);

        // sticky_clear racing a new fault on channel 3
        applyStimulus(12'h03F, '0, '0);
        waitCycles(1);
        checkOutput("sticky_ramp3", 32'(heater_enable), 32'h03F);
        waitCycles(9);
        applyStimulus(12'h03F, 12'h008, 12'h008);
        waitCycles(1);
        applyStimulus(12'h03F, '0, '0);
        checkOutput("sticky_race", 32'(err_sticky), 32'h02E);
        checkOutput("sticky_race_cnt", 32'(err_count), 32'h5);
        checkOutput("sticky_race_shed", 32'(heater_enable), 32'h037);
        applyStimulus(12'h03F, '0, 12'h002);
        waitCycles(1);
        applyStimulus(12'h03F, '0, '0);
        checkOutput("sticky_w1c", 32'(err_sticky), 32'h02C);
        checkOutput("sticky_clear3", 32'(heater_err_clear), 32'h008);
        waitCycles(4);
        checkOutput("sticky_clear3_end", 32'(heater_err_clear), 32'h0);
        waitCycles(1);
        checkOutput("sticky_reen3", 32'(heater_enable), 32'h03F);
        waitCycles(9);

        // Concurrency cap with every channel requested
        rst_n = 1'b0;
        applyStimulus(12'hFFF, '0, '0);
        waitCycles(1);
        checkOutput("cap_rst_sticky", 32'(err_sticky), 32'h0);
        checkOutput("cap_rst_errcnt", 32'(err_count), 32'h0);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("cap_en0", 32'(heater_enable), 32'h001);
        for (int k = 1; k < MAX_ON; k++) begin
            waitCycles(9);
            checkOutput("cap_step", 32'(heater_enable), 32'((1 << (k + 1)) - 1));
        end
        checkOutput("cap_active", 32'(active_count), 32'h8);
        waitCycles(9);
        checkOutput("cap_hold_at_max", 32'(heater_enable), 32'h0FF);
        waitCycles(10);
        checkOutput("cap_still_max", 32'(heater_enable), 32'h0FF);
        checkOutput("cap_busy", 32'(busy), 32'h0);
        applyStimulus(12'hFFB, '0, '0);
        waitCycles(1);
        checkOutput("cap_drop2", 32'(heater_enable), 32'h0FB);
        checkOutput("cap_drop2_active", 32'(active_count), 32'h7);
        waitCycles(1);
        checkOutput("cap_ch8", 32'(heater_enable), 32'h1FB);
        waitCycles(9);

        // Asynchronous reset in the middle of a clear pulse
        applyStimulus(12'hFFB, 12'h001, '0);
        waitCycles(1);
        applyStimulus(12'hFFB, '0, '0);
        waitCycles(2);
        checkOutput("midclr_pulse", 32'(heater_err_clear), 32'h001);
        rst_n = 1'b0;
        #1;
        checkOutput("midclr_rst_en", 32'(heater_enable), 32'h0);
        checkOutput("midclr_rst_clr", 32'(heater_err_clear), 32'h0);
        checkOutput("midclr_rst_sticky", 32'(err_sticky), 32'h0);
        checkOutput("midclr_rst_active", 32'(active_count), 32'h0);
        checkOutput("midclr_rst_errcnt", 32'(err_count), 32'h0);
        checkOutput("midclr_rst_busy", 32'(busy), 32'h0);
        waitCycles(1);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("midclr_restart", 32'(heater_enable), 32'h001);
        checkOutput("midclr_restart_busy", 32'(busy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
